// File: rtl/snake_pkg.sv
// Shared definitions for the snake game engine.
//   state_e   : engine FSM states
//   dir_e     : movement directions
//   KEY_*     : PS/2 scan codes the engine reacts to
//   is_arrow / key_to_dir / reverse_dir : key decode helpers
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam logic [7:0] KEY_UP      = 8'h75;
  localparam logic [7:0] KEY_DOWN    = 8'h72;
  localparam logic [7:0] KEY_LEFT    = 8'h6B;
  localparam logic [7:0] KEY_RIGHT   = 8'h74;
  localparam logic [7:0] KEY_RESTART = 8'h29;

  function automatic logic is_arrow(input logic [7:0] code);
    return (code == KEY_UP) || (code == KEY_DOWN) ||
           (code == KEY_LEFT) || (code == KEY_RIGHT);
  endfunction

  function automatic dir_e key_to_dir(input logic [7:0] code);
    case (code)
      KEY_UP:    return DIR_UP;
      KEY_DOWN:  return DIR_DOWN;
      KEY_LEFT:  return DIR_LEFT;
      default:   return DIR_RIGHT;
    endcase
  endfunction

  function automatic dir_e reverse_dir(input dir_e d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      default:   return DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_if.sv
// Bus between the game host and snake_engine.
//   tick, key_valid, key_code, grow, qx, qy : host -> engine
//   q_hit, q_head, head_x, head_y, length,
//   running, died                          : engine -> host
// XW / YW / LW must match the engine's cell-coordinate and length widths.
interface snake_if #(
  parameter int XW = 5,
  parameter int YW = 5,
  parameter int LW = 5
);
  logic          tick;
  logic          key_valid;
  logic [7:0]    key_code;
  logic          grow;
  logic [XW-1:0] qx;
  logic [YW-1:0] qy;
  logic          q_hit;
  logic          q_head;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [LW-1:0] length;
  logic          running;
  logic          died;

  modport master (
    output tick, key_valid, key_code, grow, qx, qy,
    input  q_hit, q_head, head_x, head_y, length, running, died
  );

  modport slave (
    input  tick, key_valid, key_code, grow, qx, qy,
    output q_hit, q_head, head_x, head_y, length, running, died
  );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Direction control for snake_engine.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : game start; key direction becomes both pending and last-moved
//   init       : reload the initial direction (right)
//   run_en     : arrow keys may update the pending direction
//   move       : a move happens this cycle (pending becomes last-moved)
//   key_valid, key_code : keyboard strobe and scan code
//   move_dir   : direction the next move will take
module snake_dir_ctrl
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       init,
  input  logic       run_en,
  input  logic       move,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output dir_e       move_dir
);

  dir_e pend_r;
  dir_e last_r;
  dir_e key_dir_s;
  dir_e ref_dir_s;
  logic accept_s;

  // Decode the key and decide whether it may replace the pending direction.
  // In a move cycle the direction being moved right now is the reference,
  // so a same-cycle key is judged against it and lands on the next move.
  always_comb begin
    key_dir_s = key_to_dir(key_code);
    ref_dir_s = move ? pend_r : last_r;
    accept_s  = run_en & key_valid & is_arrow(key_code) &
                (key_dir_s != reverse_dir(ref_dir_s));
  end

  // Pending and last-moved direction registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_r <= DIR_RIGHT;
      last_r <= DIR_RIGHT;
    end else if (start) begin
      pend_r <= key_dir_s;
      last_r <= key_dir_s;
    end else if (init) begin
      pend_r <= DIR_RIGHT;
      last_r <= DIR_RIGHT;
    end else begin
      if (move) begin
        last_r <= pend_r;
      end
      if (accept_s) begin
        pend_r <= key_dir_s;
      end
    end
  end

  assign move_dir = pend_r;

endmodule

// File: rtl/snake_engine.sv
// Snake game engine: FSM (IDLE/RUN/DEAD), move timer, segment store,
// collision detection and a registered cell query port.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : snake_if.slave (tick, keys, grow, query in; status out)
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int STEP_DIV = 4
)(
  input  logic    clk,
  input  logic    rst_n,
  snake_if.slave  bus
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [YW-1:0] HOME_Y   = YW'(GRID_H / 2);
  localparam logic [XW-1:0] LAST_X   = XW'(GRID_W - 1);
  localparam logic [YW-1:0] LAST_Y   = YW'(GRID_H - 1);
  localparam logic [LW-1:0] INIT_L   = LW'(INIT_LEN);
  localparam logic [LW-1:0] MAX_L    = LW'(MAX_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);

  // Initial column of segment i; indices past the grid edge wrap but sit
  // beyond the length, so they are never visible.
  function automatic logic [XW-1:0] init_x(input int i);
    return XW'(GRID_W / 2 - i);
  endfunction

  state_e        state_r;
  state_e        state_nx_s;
  logic [XW-1:0] seg_x_r [MAX_LEN];
  logic [YW-1:0] seg_y_r [MAX_LEN];
  logic [LW-1:0] len_r;
  logic          grow_pend_r;
  logic [CW-1:0] cnt_r;
  logic          died_r;
  logic          q_hit_r;
  logic          q_head_r;

  dir_e          move_dir_s;
  logic          arrow_s;
  logic          start_s;
  logic          restart_s;
  logic          reinit_s;
  logic          move_s;
  logic          grow_now_s;
  logic [LW-1:0] body_lim_s;
  logic [XW-1:0] nx_x_s;
  logic [YW-1:0] nx_y_s;
  logic          wall_s;
  logic          self_s;
  logic          collide_s;
  logic          hit_s;
  logic          head_s;

  snake_dir_ctrl u_dir (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_s),
    .init      (reinit_s),
    .run_en    (state_r == ST_RUN),
    .move      (move_s),
    .key_valid (bus.key_valid),
    .key_code  (bus.key_code),
    .move_dir  (move_dir_s)
  );

  // Event decode: start, restart, move timing and whether this move grows.
  always_comb begin
    arrow_s    = bus.key_valid & is_arrow(bus.key_code);
    start_s    = (state_r == ST_IDLE) & arrow_s;
    restart_s  = (state_r == ST_DEAD) & bus.key_valid & (bus.key_code == KEY_RESTART);
    reinit_s   = (state_r == ST_IDLE) | restart_s;
    move_s     = (state_r == ST_RUN) & bus.tick & (cnt_r == CNT_LAST);
    grow_now_s = (grow_pend_r | bus.grow) & (len_r != MAX_L);
    // The tail cell stays occupied only when the move grows the snake.
    body_lim_s = grow_now_s ? len_r : (len_r - LW'(1));
  end

  // Next head cell and wall check; no wrap-around at the edges.
  always_comb begin
    nx_x_s = seg_x_r[0];
    nx_y_s = seg_y_r[0];
    wall_s = 1'b0;
    case (move_dir_s)
      DIR_UP: begin
        if (seg_y_r[0] == {YW{1'b0}}) wall_s = 1'b1;
        else                          nx_y_s = seg_y_r[0] - YW'(1);
      end
      DIR_DOWN: begin
        if (seg_y_r[0] == LAST_Y) wall_s = 1'b1;
        else                      nx_y_s = seg_y_r[0] + YW'(1);
      end
      DIR_LEFT: begin
        if (seg_x_r[0] == {XW{1'b0}}) wall_s = 1'b1;
        else                          nx_x_s = seg_x_r[0] - XW'(1);
      end
      DIR_RIGHT: begin
        if (seg_x_r[0] == LAST_X) wall_s = 1'b1;
        else                      nx_x_s = seg_x_r[0] + XW'(1);
      end
      default: wall_s = 1'b0;
    endcase
  end

  // Self-collision and query match over the live segments.
  always_comb begin
    self_s = 1'b0;
    hit_s  = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      self_s = self_s | ((LW'(i) < body_lim_s) &
                         (seg_x_r[i] == nx_x_s) & (seg_y_r[i] == nx_y_s));
      hit_s  = hit_s  | ((LW'(i) < len_r) &
                         (seg_x_r[i] == bus.qx) & (seg_y_r[i] == bus.qy));
    end
    head_s    = (seg_x_r[0] == bus.qx) & (seg_y_r[0] == bus.qy);
    collide_s = wall_s | self_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nx_s = ST_RUN;
        else         state_nx_s = ST_IDLE;
      end
      ST_RUN: begin
        if (move_s & collide_s) state_nx_s = ST_DEAD;
        else                    state_nx_s = ST_RUN;
      end
      ST_DEAD: begin
        if (restart_s) state_nx_s = ST_IDLE;
        else           state_nx_s = ST_DEAD;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM state register and death pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      died_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      died_r  <= move_s & collide_s;
    end
  end

  // Move timer: counts ticks only while running.
  always_ff @(posedge clk) begin
    if (!rst_n || (state_r != ST_RUN)) begin
      cnt_r <= {CW{1'b0}};
    end else if (bus.tick) begin
      cnt_r <= (cnt_r == CNT_LAST) ? {CW{1'b0}} : (cnt_r + CW'(1));
    end
  end

  // Segment store, length and sticky grow request.
  always_ff @(posedge clk) begin
    if (!rst_n || reinit_s) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_r[i] <= init_x(i);
        seg_y_r[i] <= HOME_Y;
      end
      len_r       <= INIT_L;
      grow_pend_r <= 1'b0;
    end else if (move_s && !collide_s) begin
      for (int i = MAX_LEN - 1; i > 0; i--) begin
        seg_x_r[i] <= seg_x_r[i-1];
        seg_y_r[i] <= seg_y_r[i-1];
      end
      seg_x_r[0]  <= nx_x_s;
      seg_y_r[0]  <= nx_y_s;
      len_r       <= grow_now_s ? (len_r + LW'(1)) : len_r;
      grow_pend_r <= 1'b0;
    end else begin
      grow_pend_r <= grow_pend_r | bus.grow;
    end
  end

  // Registered cell query.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_hit_r  <= 1'b0;
      q_head_r <= 1'b0;
    end else begin
      q_hit_r  <= hit_s;
      q_head_r <= head_s;
    end
  end

  assign bus.q_hit   = q_hit_r;
  assign bus.q_head  = q_head_r;
  assign bus.head_x  = seg_x_r[0];
  assign bus.head_y  = seg_y_r[0];
  assign bus.length  = len_r;
  assign bus.running = (state_r == ST_RUN);
  assign bus.died    = died_r;

endmodule

// File: tb/tb_snake_engine.sv
// Scoreboard bench for snake_engine: stimulus pushes expected outputs into
// queues, a monitor on the falling edge pops and compares them.
module tb_snake_engine;

  typedef struct packed {
    logic       st_en;
    logic [4:0] hx;
    logic [4:0] hy;
    logic [4:0] len;
    logic       run;
    logic       q_en;
    logic       qhit;
    logic       qhead;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  snake_if #(.XW(5), .YW(5), .LW(5)) bus ();

  snake_engine #(
    .GRID_W(32), .GRID_H(24), .MAX_LEN(16), .INIT_LEN(3), .STEP_DIV(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    checks = 0;
  int    errors = 0;
  logic  chk_req = 1'b0;
  logic  final_req = 1'b0;
  exp_t  exp_q[$];
  string name_q[$];
  int    died_q[$];
  exp_t  mon_e;
  string mon_nm;
  int    mon_dx;

  // Monitor: compare on request, and check every died pulse.
  always @(negedge clk) begin
    if (chk_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: check requested with no expectation");
      end else begin
        mon_e  = exp_q.pop_front();
        mon_nm = name_q.pop_front();
        if ((mon_e.st_en && (bus.head_x !== mon_e.hx || bus.head_y !== mon_e.hy ||
                             bus.length !== mon_e.len || bus.running !== mon_e.run)) ||
            (mon_e.q_en && (bus.q_hit !== mon_e.qhit || bus.q_head !== mon_e.qhead))) begin
          errors++;
          $display("FAIL %s: got head=(%0d,%0d) len=%0d run=%0d q_hit=%0d q_head=%0d want head=(%0d,%0d) len=%0d run=%0d q_hit=%0d q_head=%0d (st_en=%0d q_en=%0d)",
                   mon_nm, bus.head_x, bus.head_y, bus.length, bus.running, bus.q_hit, bus.q_head,
                   mon_e.hx, mon_e.hy, mon_e.len, mon_e.run, mon_e.qhit, mon_e.qhead,
                   mon_e.st_en, mon_e.q_en);
        end
      end
    end
    if (bus.died === 1'b1) begin
      checks++;
      if (died_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_died: got died=1 head_x=%0d want no pulse", bus.head_x);
      end else begin
        mon_dx = died_q.pop_front();
        if (bus.head_x !== 5'(mon_dx) || bus.running !== 1'b0) begin
          errors++;
          $display("FAIL died_state: got head_x=%0d running=%0d want head_x=%0d running=0",
                   bus.head_x, bus.running, mon_dx);
        end
      end
    end
    if (final_req) begin
      checks++;
      if (exp_q.size() != 0 || died_q.size() != 0) begin
        errors++;
        $display("FAIL leftover: got %0d checks and %0d deaths pending want 0 and 0",
                 exp_q.size(), died_q.size());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.tick      = 1'b0;
    bus.key_valid = 1'b0;
    bus.grow      = 1'b0;
  endtask

  task automatic press(input logic [7:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      step();
      step();
    end
  endtask

  task automatic expect_out(input string nm, input bit st_en, input int hx, input int hy,
                            input int len, input bit run, input bit q_en,
                            input bit qhit, input bit qhead);
    exp_t e;
    e.st_en = st_en;
    e.hx    = 5'(hx);
    e.hy    = 5'(hy);
    e.len   = 5'(len);
    e.run   = run;
    e.q_en  = q_en;
    e.qhit  = qhit;
    e.qhead = qhead;
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk_req = 1'b1;
    step();
    chk_req = 1'b0;
  endtask

  task automatic expect_st(input string nm, input int hx, input int hy, input int len,
                           input bit run);
    expect_out(nm, 1'b1, hx, hy, len, run, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_q(input string nm, input int x, input int y,
                          input bit qhit, input bit qhead);
    bus.qx = 5'(x);
    bus.qy = 5'(y);
    step();
    expect_out(nm, 1'b0, 0, 0, 0, 1'b0, 1'b1, qhit, qhead);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick = 1'b0; bus.key_valid = 1'b0; bus.key_code = 8'h00;
    bus.grow = 1'b0; bus.qx = 5'd16; bus.qy = 5'd12;

    // Reset state, checked while reset is still held.
    rst_n = 1'b0;
    step();
    step();
    expect_out("reset_state", 1'b1, 16, 12, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;

    // IDLE body queries.
    expect_q("idle_q_head", 16, 12, 1'b1, 1'b1);
    expect_q("idle_q_tail", 14, 12, 1'b1, 1'b0);
    expect_q("idle_q_beyond_len", 13, 12, 1'b0, 1'b0);

    // Start right; first move after four ticks.
    press(8'h74);
    expect_st("start_running", 16, 12, 3, 1'b1);
    ticks(3);
    expect_st("no_move_before_wrap", 16, 12, 3, 1'b1);
    ticks(1);
    expect_st("first_move", 17, 12, 3, 1'b1);

    // Key in the same cycle as a move applies to the following move.
    ticks(3);
    bus.tick = 1'b1; bus.key_valid = 1'b1; bus.key_code = 8'h75;
    step();
    expect_st("same_cycle_key_deferred", 18, 12, 3, 1'b1);
    ticks(4);
    expect_st("deferred_key_used", 18, 11, 3, 1'b1);

    // Reverse key discarded; then run right into the wall.
    do_reset();
    press(8'h74);
    press(8'h6B);
    ticks(8);
    expect_st("reverse_rejected", 18, 12, 3, 1'b1);
    ticks(52);
    expect_st("at_right_edge", 31, 12, 3, 1'b1);
    died_q.push_back(31);
    ticks(4);
    expect_st("wall_death", 31, 12, 3, 1'b0);
    ticks(4);
    press(8'h74);
    expect_st("dead_ignores_arrow", 31, 12, 3, 1'b0);

    // Growth to saturation along an L-shaped path.
    do_reset();
    press(8'h75);
    for (int i = 0; i < 10; i++) begin
      bus.grow = 1'b1;
      step();
      ticks(4);
    end
    expect_st("grow_up_leg", 16, 2, 13, 1'b1);
    press(8'h6B);
    for (int i = 0; i < 10; i++) begin
      bus.grow = 1'b1;
      step();
      ticks(4);
    end
    expect_st("grow_saturated", 6, 2, 16, 1'b1);
    expect_q("sat_q_tail", 16, 7, 1'b1, 1'b0);
    expect_q("sat_q_dropped", 16, 8, 1'b0, 1'b0);
    expect_q("sat_q_head", 6, 2, 1'b1, 1'b1);

    // Length 5, mixed keys, U-turn self-collision, restart.
    do_reset();
    press(8'h74);
    bus.grow = 1'b1; step(); ticks(4);
    bus.grow = 1'b1; step(); ticks(4);
    expect_st("len5", 18, 12, 5, 1'b1);
    press(8'h75);
    press(8'h6B);
    press(8'h72);
    ticks(4);
    expect_st("last_key_down", 18, 13, 5, 1'b1);
    press(8'h6B);
    ticks(4);
    expect_st("turn_left", 17, 13, 5, 1'b1);
    died_q.push_back(17);
    press(8'h75);
    ticks(4);
    expect_st("self_collision", 17, 13, 5, 1'b0);
    press(8'h29);
    expect_st("restart_idle", 16, 12, 3, 1'b0);

    // Reset in the cycle of a move.
    press(8'h74);
    ticks(3);
    bus.qx = 5'd16; bus.qy = 5'd12;
    step();
    rst_n = 1'b0;
    bus.tick = 1'b1;
    step();
    rst_n = 1'b1;
    expect_out("reset_mid_move", 1'b1, 16, 12, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("after_reset_query", 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);

    final_req = 1'b1;
    step();
    final_req = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_engine.md
SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 SHALL have parameter GRID_W, default 32, meaning playfield width in cells.
REQ-002 SHALL have parameter GRID_H, default 24, meaning playfield height in cells.
REQ-003 SHALL have parameter MAX_LEN, default 16, meaning segment storage depth (at least 4).
REQ-004 SHALL have parameter INIT_LEN, default 3, meaning length after init (2 to MAX_LEN).
REQ-005 SHALL have parameter STEP_DIV, default 4, meaning tick pulses per snake move (at least 1).
REQ-006 clk  in  1  system clock; one clock; all logic on its rising edge.
REQ-007 rst_n  in  1  reset, synchronous and active-low.
REQ-008 tick  in  1  one-cycle pulse per video frame.
REQ-009 key_valid  in  1  one-cycle strobe qualifying key_code.
REQ-010 key_code  in  8  PS/2 scan code: 0x75 up, 0x72 down, 0x6B left, 0x74 right, 0x29 restart.
REQ-011 grow  in  1  one-cycle request to add one segment.
REQ-012 qx / qy  in  XW / YW  query cell, where XW = clog2(GRID_W) and YW = clog2(GRID_H).
REQ-013 q_hit  out  1  the query cell holds any segment.
REQ-014 q_head  out  1  the query cell holds the head.
REQ-015 head_x / head_y  out  XW / YW  current head cell.
REQ-016 length  out  clog2(MAX_LEN+1)  current segment count.
REQ-017 running  out  1  high in state RUN.
REQ-018 died  out  1  one-cycle pulse on death.

Function
REQ-019 SHALL implement states IDLE, RUN, DEAD.
REQ-020 IDLE SHALL hold the snake at its init position.
REQ-021 IDLE -> RUN on key_valid with any arrow code; that code becomes the initial direction.
REQ-022 RUN -> DEAD on collision; died SHALL pulse in the same cycle the state registers DEAD.
REQ-023 DEAD -> IDLE on key_valid with 0x29; this reinitialises the snake; all other keys are ignored in DEAD.
REQ-024 Init position: head at (GRID_W/2, GRID_H/2); segment i at (GRID_W/2 - i, GRID_H/2); direction right; length INIT_LEN.
REQ-025 In RUN, a tick counter SHALL count tick pulses 0..STEP_DIV-1; a move occurs in the cycle the counter wraps; the counter holds 0 outside RUN.
REQ-026 Arrow keys in RUN SHALL load a pending direction; the direct reverse of the last moved direction is discarded; the last accepted key before a move wins.
REQ-027 A key arriving in the same cycle as a move SHALL apply to the following move only.
REQ-028 Move: next head = head +/- 1 on one axis; segments shift down one index; index 0 takes the new head.
REQ-029 No wrap-around: a next head with x < 0, x >= GRID_W, y < 0 or y >= GRID_H is a wall collision; the snake is not updated.
REQ-030 Self collision: next head equals segment i for i < length-1 (tail vacates), or i < length if the move grows; the snake is not updated.
REQ-031 grow SHALL set a sticky pending flag, consumed at the next move; length increments, saturating at MAX_LEN, after which grow is a no-op.
REQ-032 Segments at index >= length are don't-care and SHALL never assert q_hit.
REQ-033 q_hit and q_head SHALL be registered, with 1-cycle latency from qx/qy; both are valid in every state.

Reset
REQ-034 rst_n low on a clock edge SHALL put the block in IDLE with init position, length = INIT_LEN, grow pending cleared, tick counter 0, q_hit = 0, q_head = 0, died = 0, running = 0; this holds mid-move too.

Structure
REQ-035 A shared package snake_pkg SHALL hold the state enum, the direction enum, and the scan-code constants (0x75, 0x72, 0x6B, 0x74, 0x29).
REQ-036 One sub-module snake_dir_ctrl SHALL own key decode, reverse rejection and pending direction; the segment store and FSM stay in snake_engine.

Verification
REQ-037 Reset, then key 0x74, then 4 ticks -> running = 1, head moves (16,12) -> (17,12), length = 3.
REQ-038 Direction right, key 0x6B then 8 ticks -> direction stays right, head (18,12) after those 8 ticks.
REQ-039 Drive head to x = 31 heading right, one more move -> died pulses once, state DEAD, head_x stays 31.
REQ-040 grow pulsed 20 times with MAX_LEN = 16 plus moves -> length saturates at 16; query at the old tail cell, 1 cycle later -> q_hit = 1.
REQ-041 Length 5, key sequence up, left, down within a single move period -> only down-reversal rule applied; tight U-turn causes self-collision died; then key 0x29 -> IDLE, length = 3.
REQ-042 Assert rst_n low in the cycle of a move -> next cycle shows the init position, q_hit = 0 and running = 0.
